binary_decoder: RTL and testbench
=================================

BINARY_DECODER -- requirements
Module: binary_decoder

Interface
- REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
- REQ-002 ENCODE_WIDTH, default 2, SHALL set the binary input width; legal range 1..8.
- REQ-003 DECODE_WIDTH, default 2**ENCODE_WIDTH, SHALL set the one-hot output width; it is a derived localparam and SHALL NOT be overridable.
- REQ-004 clk  input  1  SHALL be the rising-edge clock.
- REQ-005 rst_n  input  1  SHALL be the asynchronous active-low reset.
- REQ-006 in  input  ENCODE_WIDTH  SHALL carry the binary index to decode.
- REQ-007 en  input  1  SHALL qualify in; the decode is active only when en is high.
- REQ-008 out  output  DECODE_WIDTH  SHALL be the combinational one-hot decode of in.
- REQ-009 out_q  output  DECODE_WIDTH  SHALL be the registered one-hot decode.
- REQ-010 out_valid  output  1  SHALL be high when out_q holds a decode captured with en high.

Function
- REQ-011 out SHALL equal 1 shifted left by in when en=1, and all-zero when en=0, with no clock dependency.
- REQ-012 out SHALL have exactly one bit set whenever en=1, for every value of in including the maximum (2**ENCODE_WIDTH-1 sets the MSB).
- REQ-013 On each rising clk with en=1, out_q SHALL load the decode of in and out_valid SHALL go to 1, giving a latency of one cycle.
- REQ-014 On each rising clk with en=0, out_q SHALL hold its previous value and out_valid SHALL go to 0.
- REQ-015 An X or Z value on any bit of in while en=1 SHALL be treated as don't-care by the RTL; the bench SHALL drive only known values.
- REQ-016 Input changes between clock edges SHALL affect only out; out_q SHALL change only at clock edges or on reset.

Reset
- REQ-017 While rst_n=0, out_q SHALL be all-zero and out_valid SHALL be 0, taking effect immediately with no clock required.
- REQ-018 Release of rst_n SHALL be synchronous to clk; the first capture SHALL occur on the first rising edge after release.
- REQ-019 A reset asserted mid-operation SHALL discard any held value; out SHALL remain purely combinational and unaffected by reset.

Configuration
- REQ-020 When BINARY_DECODER_CHECK_EN is defined, the block SHALL add a registered output chk_err (1 bit, reset 0).
- REQ-021 With BINARY_DECODER_CHECK_EN defined, the block SHALL re-encode out_q to binary and compare it against a registered copy of in, setting chk_err=1 for one cycle on any mismatch or on a non-one-hot out_q while out_valid=1.
- REQ-022 Without BINARY_DECODER_CHECK_EN, the chk_err port and all of its logic SHALL be absent.

Structure
- REQ-023 The package binary_decoder_pkg SHALL hold the default ENCODE_WIDTH constant, the maximum-width constant (8), and a function returning the one-hot decode of an index.
- REQ-024 The one sub-module onehot_encoder (one-hot in, binary out, plus a not_onehot flag) SHALL be instantiated only under BINARY_DECODER_CHECK_EN.

Verification
- REQ-025 Scenario: ENCODE_WIDTH=2, en=1, in swept 0,1,2,3 on successive posedges -> out = 0001, 0010, 0100, 1000 immediately, and out_q equals the same sequence one cycle later with out_valid=1.
- REQ-026 Scenario: en=0 with in=2 -> out=0000, out_q holds its prior value, and out_valid=0 after the edge.
- REQ-027 Scenario: rst_n pulsed low mid-sweep, asynchronous to clk -> out_q=0000 and out_valid=0 immediately; capture resumes on the first edge after release.
- REQ-028 Scenario: ENCODE_WIDTH=3, in=7, en=1 -> out=1000_0000; an exhaustive sweep of 0..7 shows exactly one bit set at each step.
- REQ-029 Scenario: with BINARY_DECODER_CHECK_EN defined, a forced corruption of out_q (hierarchical force to 0011) -> chk_err=1 on the next cycle; the unforced sweep shows chk_err=0 throughout.

Source files
------------

// File: rtl/binary_decoder_pkg.sv
// Shared constants and the one-hot decode helper for binary_decoder.
package binary_decoder_pkg;

  localparam int DEFAULT_ENCODE_WIDTH = 2;
  localparam int MAX_ENCODE_WIDTH     = 8;
  localparam int MAX_DECODE_WIDTH     = 1 << MAX_ENCODE_WIDTH;

  // One-hot decode at the widest supported size; callers truncate to their width.
  function automatic logic [MAX_DECODE_WIDTH-1:0] onehot_decode(
    input logic [MAX_ENCODE_WIDTH-1:0] idx
  );
    logic [MAX_DECODE_WIDTH-1:0] result;
    result      = '0;
    result[idx] = 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/binary_decoder_onehot_encoder.sv
// onehot_encoder: re-encodes a one-hot vector to its binary index and flags
// any vector that does not have exactly one bit set.
module onehot_encoder #(
  parameter int ENCODE_WIDTH = 2,
  parameter int DECODE_WIDTH = 1 << ENCODE_WIDTH
) (
  input  logic [DECODE_WIDTH-1:0] onehot,
  output logic [ENCODE_WIDTH-1:0] index,
  output logic                    not_onehot
);

  // Each set bit contributes its own position; OR-ing them yields the index
  // when the vector really is one-hot.
  logic [ENCODE_WIDTH-1:0] contrib [DECODE_WIDTH];

  for (genvar gi = 0; gi < DECODE_WIDTH; gi++) begin : g_contrib
    assign contrib[gi] = onehot[gi] ? ENCODE_WIDTH'(gi) : '0;
  end

  logic [ENCODE_WIDTH:0] set_count;

  // Reduce contributions to an index and count set bits for the one-hot test.
  always_comb begin
    index     = '0;
    set_count = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      index     = index | contrib[i];
      set_count = set_count + {{ENCODE_WIDTH{1'b0}}, onehot[i]};
    end
  end

  assign not_onehot = (set_count != {{ENCODE_WIDTH{1'b0}}, 1'b1});

endmodule

// File: rtl/binary_decoder.sv
// binary_decoder: combinational and registered one-hot decode of a binary index.
// Optional self-check enabled by defining BINARY_DECODER_CHECK_EN, which adds
// the chk_err output and an onehot_encoder instance that re-encodes out_q.
module binary_decoder
  import binary_decoder_pkg::*;
#(
  parameter  int ENCODE_WIDTH = DEFAULT_ENCODE_WIDTH,
  localparam int DECODE_WIDTH = 1 << ENCODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ENCODE_WIDTH-1:0] in,
  input  logic                    en,
  output logic [DECODE_WIDTH-1:0] out,
  output logic [DECODE_WIDTH-1:0] out_q,
`ifdef BINARY_DECODER_CHECK_EN
  output logic                    out_valid,
  output logic                    chk_err
`else
  output logic                    out_valid
`endif
);

  logic [DECODE_WIDTH-1:0] decode;
  logic [DECODE_WIDTH-1:0] out_q_reg;
  logic                    out_valid_reg;

  // Widen the index to the package width, decode, then keep only our bits.
  assign decode = DECODE_WIDTH'(onehot_decode(MAX_ENCODE_WIDTH'(in)));

  // Combinational path is independent of clock and reset.
  assign out = en ? decode : '0;

  // Capture the decode when enabled; otherwise hold the value but drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= en;
      if (en) begin
        out_q_reg <= decode;
      end
    end
  end

  assign out_q     = out_q_reg;
  assign out_valid = out_valid_reg;

`ifdef BINARY_DECODER_CHECK_EN
  logic [ENCODE_WIDTH-1:0] in_q_reg;
  logic [ENCODE_WIDTH-1:0] reenc_index;
  logic                    reenc_not_onehot;
  logic                    chk_err_reg;
  logic                    chk_err_next;

  // Shadow copy of the index that produced the current out_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q_reg <= '0;
    end else if (en) begin
      in_q_reg <= in;
    end
  end

  onehot_encoder #(
    .ENCODE_WIDTH(ENCODE_WIDTH),
    .DECODE_WIDTH(DECODE_WIDTH)
  ) u_onehot_encoder (
    .onehot    (out_q),
    .index     (reenc_index),
    .not_onehot(reenc_not_onehot)
  );

  // An error is only meaningful while out_q holds a valid capture.
  always_comb begin
    chk_err_next = out_valid_reg && (reenc_not_onehot || (reenc_index != in_q_reg));
  end

  // Register the error so it pulses for each cycle the mismatch is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_reg <= 1'b0;
    end else begin
      chk_err_reg <= chk_err_next;
    end
  end

  assign chk_err = chk_err_reg;
`endif

endmodule

// File: tb/tb_binary_decoder.sv
// Directed testbench for binary_decoder at ENCODE_WIDTH=2 and ENCODE_WIDTH=3.
// Exercises the check logic as well when BINARY_DECODER_CHECK_EN is defined.
module tb_binary_decoder;

  logic       clk;
  logic       rst_n;
  logic [1:0] in2;
  logic       en2;
  logic [3:0] out2;
  logic [3:0] out_q2;
  logic       out_valid2;
  logic [2:0] in3;
  logic       en3;
  logic [7:0] out3;
  logic [7:0] out_q3;
  logic       out_valid3;
`ifdef BINARY_DECODER_CHECK_EN
  logic       chk_err2;
  logic       chk_err3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp2 [4];
  logic [7:0] exp3 [8];

  binary_decoder #(.ENCODE_WIDTH(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in2),
    .en       (en2),
    .out      (out2),
    .out_q    (out_q2),
`ifdef BINARY_DECODER_CHECK_EN
    .out_valid(out_valid2),
    .chk_err  (chk_err2)
`else
    .out_valid(out_valid2)
`endif
  );

  binary_decoder #(.ENCODE_WIDTH(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in3),
    .en       (en3),
    .out      (out3),
    .out_q    (out_q3),
`ifdef BINARY_DECODER_CHECK_EN
    .out_valid(out_valid3),
    .chk_err  (chk_err3)
`else
    .out_valid(out_valid3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp3 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    rst_n = 1'b0;
    en2 = 1'b0; in2 = 2'd0;
    en3 = 1'b0; in3 = 3'd0;
    #2;
    check("reset out_q", 32'(out_q2), 32'h0);
    check("reset out_valid", 32'(out_valid2), 32'h0);
    // Combinational output ignores reset.
    en2 = 1'b1; in2 = 2'd1;
    #1;
    check("out during reset", 32'(out2), 32'h2);
    en2 = 1'b0;
    tick();
    check("out_q held in reset", 32'(out_q2), 32'h0);
    rst_n = 1'b1;

    // Sweep 0..3 at width 2.
    for (int i = 0; i < 4; i++) begin
      in2 = 2'(i); en2 = 1'b1;
      #1;
      check($sformatf("w2 out in=%0d", i), 32'(out2), 32'(exp2[i]));
      tick();
      check($sformatf("w2 out_q in=%0d", i), 32'(out_q2), 32'(exp2[i]));
      check($sformatf("w2 valid in=%0d", i), 32'(out_valid2), 32'h1);
`ifdef BINARY_DECODER_CHECK_EN
      check($sformatf("w2 chk_err in=%0d", i), 32'(chk_err2), 32'h0);
`endif
    end

    // Disabled: out goes to zero, out_q holds, valid drops.
    en2 = 1'b0; in2 = 2'd2;
    #1;
    check("en0 out", 32'(out2), 32'h0);
    tick();
    check("en0 out_q hold", 32'(out_q2), 32'h8);
    check("en0 valid", 32'(out_valid2), 32'h0);

    // Capture, then change input mid-cycle: only out moves.
    en2 = 1'b1; in2 = 2'd1;
    tick();
    check("pre-reset out_q", 32'(out_q2), 32'h2);
    in2 = 2'd2;
    #2;
    check("mid-cycle out", 32'(out2), 32'h4);
    check("mid-cycle out_q stable", 32'(out_q2), 32'h2);

    // Asynchronous reset pulse between edges.
    rst_n = 1'b0;
    #1;
    check("async rst out_q", 32'(out_q2), 32'h0);
    check("async rst valid", 32'(out_valid2), 32'h0);
    check("async rst out", 32'(out2), 32'h4);
    rst_n = 1'b1;
    tick();
    check("post-rst out_q", 32'(out_q2), 32'h4);
    check("post-rst valid", 32'(out_valid2), 32'h1);
    en2 = 1'b0;

    // Width 3: maximum index then exhaustive sweep.
    en3 = 1'b1; in3 = 3'd7;
    #1;
    check("w3 out in=7", 32'(out3), 32'h80);
    for (int i = 0; i < 8; i++) begin
      in3 = 3'(i);
      #1;
      check($sformatf("w3 out in=%0d", i), 32'(out3), 32'(exp3[i]));
      check($sformatf("w3 ones in=%0d", i), 32'($countones(out3)), 32'h1);
      tick();
      check($sformatf("w3 out_q in=%0d", i), 32'(out_q3), 32'(exp3[i]));
`ifdef BINARY_DECODER_CHECK_EN
      check($sformatf("w3 chk_err in=%0d", i), 32'(chk_err3), 32'h0);
`endif
    end
    en3 = 1'b0;

`ifdef BINARY_DECODER_CHECK_EN
    // Corrupt the stored decode and expect the checker to flag it.
    en2 = 1'b1; in2 = 2'd1;
    tick();
    check("chk pre-force", 32'(chk_err2), 32'h0);
    force dut2.out_q_reg = 4'b0011;
    tick();
    check("chk forced", 32'(chk_err2), 32'h1);
    release dut2.out_q_reg;
    tick();
    tick();
    check("chk recovered", 32'(chk_err2), 32'h0);
    en2 = 1'b0;
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
